demux_router: RTL and testbench
===============================

DEMUX_ROUTER -- requirements
Module: demux_router

Interface
REQ-001 The module SHALL expose parameter WIDTH, default 8, data width per beat.
REQ-002 The module SHALL expose parameter NCH, default 4, number of output channels, a power of two and at least 2.
REQ-003 The module SHALL expose parameter SELW, default 2, select width, equal to log2(NCH).
REQ-004 The module SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-005 The module SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-006 The module SHALL have port I, input, WIDTH bits, input data.
REQ-007 The module SHALL have port in_valid, input, 1 bit, input beat offered.
REQ-008 The module SHALL have port in_ready, output, 1 bit, input beat acceptable this cycle.
REQ-009 The module SHALL have port s, input, SELW bits, target channel in addressed mode.
REQ-010 The module SHALL have port mode, input, 2 bits, routing mode: 00 addressed, 01 round-robin, 10 broadcast, 11 reserved.
REQ-011 The module SHALL have port out, output, NCH*WIDTH bits, channel k occupying bits [k*WIDTH +: WIDTH].
REQ-012 The module SHALL have port out_valid, output, NCH bits, per-channel data valid.
REQ-013 The module SHALL have port out_ready, input, NCH bits, per-channel consumer ready.
REQ-014 The module SHALL have port rr_ptr, output, SELW bits, current round-robin target.

Function
REQ-015 Each channel SHALL hold one registered entry (data plus valid); channel k is free when !out_valid[k] || out_ready[k].
REQ-016 An accept SHALL occur when in_valid && in_ready; loaded data SHALL appear on out and out_valid on the next rising edge, giving 1-cycle latency.
REQ-017 in_ready SHALL be combinational from channel state, s, mode and rr_ptr, and SHALL NOT depend on in_valid.
REQ-018 In mode 00, target = s, in_ready = free[s], and an accept loads channel s only.
REQ-019 In mode 01, target = rr_ptr, in_ready = free[rr_ptr], and an accept loads that channel and advances rr_ptr by 1 modulo NCH (NCH-1 wraps to 0).
REQ-020 In mode 10, in_ready = AND of all free[k], and an accept loads I into every channel and sets all out_valid bits.
REQ-021 In mode 11, in_ready SHALL be 0, nothing is accepted, and channel state evolves only by drains.
REQ-022 rr_ptr SHALL change only on a mode-01 accept; mode changes SHALL NOT alter it.
REQ-023 A drain (out_valid[k] && out_ready[k]) SHALL clear out_valid[k] unless channel k is reloaded in the same cycle, in which case it stays 1 with new data.
REQ-024 While out_valid[k] && !out_ready[k], channel k data SHALL be held stable.
REQ-025 Channels not targeted by an accept SHALL be unaffected except by their own drain.
REQ-026 Channel data SHALL retain its last value when invalid.

Reset
REQ-027 On rst_n low, asynchronously and independent of clk, out_valid SHALL become all 0, out all 0, and rr_ptr 0; any held beats are discarded.
REQ-028 After reset, all channels SHALL be free, so in_ready = 1 for modes 00/01/10 and 0 for mode 11.
REQ-029 Reset release SHALL take effect at the first rising clk edge with rst_n high.

Verification (WIDTH=8, NCH=4)
REQ-030 Addressed stall: mode 00, s=2, I=A5 for one beat with out_ready=0 -> next cycle out_valid=0100, ch2=A5; a second beat to s=2 sees in_ready=0 until out_ready[2]=1.
REQ-031 Simultaneous drain and load: ch1 holds 11, out_ready[1]=1, mode 00, s=1, I=3C -> in_ready=1; next cycle ch1=3C and out_valid[1] stays 1.
REQ-032 Round-robin: mode 01, beats 01..05, all out_ready=1 -> ch0,1,2,3,0 receive them in order; rr_ptr goes 0,1,2,3,0,1.
REQ-033 Broadcast: ch3 full with out_ready[3]=0, mode 10, I=FF -> in_ready=0; once out_ready[3]=1 -> accept, next cycle out_valid=1111 and all channels hold FF.
REQ-034 Reset mid-operation: rst_n driven low between edges with out_valid=1011 and rr_ptr=2 -> immediately out_valid=0000, out=0, rr_ptr=0.
REQ-035 Reserved mode: mode 11, in_valid=1 -> in_ready=0; no channel loads and rr_ptr is unchanged.

Source files
------------

// File: rtl/demux_router.sv
// One-in, NCH-out demultiplexer with a one-entry register per output channel.
// Supports addressed, round-robin and broadcast routing with per-channel backpressure.
module demux_router #(
  parameter int WIDTH = 8,
  parameter int NCH   = 4,
  parameter int SELW  = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WIDTH-1:0]     I,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [SELW-1:0]      s,
  input  logic [1:0]           mode,
  output logic [NCH*WIDTH-1:0] out,
  output logic [NCH-1:0]       out_valid,
  input  logic [NCH-1:0]       out_ready,
  output logic [SELW-1:0]      rr_ptr
);

  typedef enum logic [1:0] {
    MODE_ADDR  = 2'b00,
    MODE_RR    = 2'b01,
    MODE_BCAST = 2'b10,
    MODE_RSVD  = 2'b11
  } mode_e;

  localparam logic [NCH-1:0] ONE_HOT0 = {{(NCH-1){1'b0}}, 1'b1};

  mode_e                modeSel;
  logic [NCH-1:0]       free;
  logic [NCH-1:0]       targetMask;
  logic                 ready;
  logic                 accept;
  logic [NCH-1:0]       load;

  logic [NCH-1:0]       valid_q, valid_d;
  logic [NCH*WIDTH-1:0] data_q,  data_d;
  logic [SELW-1:0]      rr_q,    rr_d;

  assign modeSel   = mode_e'(mode);
  assign free      = ~valid_q | out_ready;
  assign in_ready  = ready;
  assign accept    = in_valid & ready;
  assign out       = data_q;
  assign out_valid = valid_q;
  assign rr_ptr    = rr_q;

  // Readiness and target set depend only on channel state, mode, s and the
  // round-robin pointer, never on in_valid.
  always_comb begin
    ready      = 1'b0;
    targetMask = '0;
    unique case (modeSel)
      MODE_ADDR: begin
        ready      = free[s];
        targetMask = ONE_HOT0 << s;
      end
      MODE_RR: begin
        ready      = free[rr_q];
        targetMask = ONE_HOT0 << rr_q;
      end
      MODE_BCAST: begin
        ready      = &free;
        targetMask = '1;
      end
      default: begin
        ready      = 1'b0;
        targetMask = '0;
      end
    endcase
  end

  always_comb begin
    load    = accept ? targetMask : '0;
    valid_d = valid_q;
    data_d  = data_q;
    rr_d    = rr_q;
    for (int k = 0; k < NCH; k++) begin
      // A reload wins over a drain so the channel stays valid with fresh data.
      if (load[k]) begin
        valid_d[k]              = 1'b1;
        data_d[k*WIDTH +: WIDTH] = I;
      end else if (valid_q[k] && out_ready[k]) begin
        valid_d[k] = 1'b0;
      end
    end
    if (accept && (modeSel == MODE_RR)) begin
      rr_d = rr_q + SELW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      data_q  <= '0;
      rr_q    <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      rr_q    <= rr_d;
    end
  end

endmodule

// File: tb/tb_demux_router.sv
// Self-checking bench for demux_router: directed scenarios plus randomized
// traffic compared against a per-channel behavioural model.
module tb_demux_router;

  localparam int WIDTH = 8;
  localparam int NCH   = 4;
  localparam int SELW  = 2;

  logic                 clk;
  logic                 rst_n;
  logic [WIDTH-1:0]     I;
  logic                 in_valid;
  logic                 in_ready;
  logic [SELW-1:0]      s;
  logic [1:0]           mode;
  logic [NCH*WIDTH-1:0] out;
  logic [NCH-1:0]       out_valid;
  logic [NCH-1:0]       out_ready;
  logic [SELW-1:0]      rr_ptr;

  int testsRun;
  int testsFailed;

  bit             mValid[NCH];
  logic [WIDTH-1:0] mData[NCH];
  int             mRr;

  demux_router #(.WIDTH(WIDTH), .NCH(NCH), .SELW(SELW)) dut (
    .clk(clk), .rst_n(rst_n), .I(I), .in_valid(in_valid), .in_ready(in_ready),
    .s(s), .mode(mode), .out(out), .out_valid(out_valid),
    .out_ready(out_ready), .rr_ptr(rr_ptr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic modelReset();
    for (int k = 0; k < NCH; k++) begin
      mValid[k] = 1'b0;
      mData[k]  = '0;
    end
    mRr = 0;
  endtask

  function automatic bit modelReady();
    bit allFree;
    allFree = 1'b1;
    for (int k = 0; k < NCH; k++)
      if (mValid[k] && !out_ready[k]) allFree = 1'b0;
    case (mode)
      2'b00: return !mValid[s] || out_ready[s];
      2'b01: return !mValid[mRr] || out_ready[mRr];
      2'b10: return allFree;
      default: return 1'b0;
    endcase
  endfunction

  // Applies one clock edge's worth of the routing rules to the model.
  task automatic modelAdvance();
    bit acc;
    bit tgt[NCH];
    acc = in_valid && modelReady();
    for (int k = 0; k < NCH; k++) begin
      tgt[k] = acc && ((mode == 2'b10) ||
                       (mode == 2'b00 && k == int'(s)) ||
                       (mode == 2'b01 && k == mRr));
    end
    for (int k = 0; k < NCH; k++) begin
      if (tgt[k]) begin
        mValid[k] = 1'b1;
        mData[k]  = I;
      end else if (mValid[k] && out_ready[k]) begin
        mValid[k] = 1'b0;
      end
    end
    if (acc && mode == 2'b01) mRr = (mRr + 1) % NCH;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    @(negedge clk);
    rst_n = 1'b0;
    in_valid = 1'b0; out_ready = '0; mode = 2'b00; s = '0; I = '0;
    #2;
    @(negedge clk);
    rst_n = 1'b1;
    modelReset();
    tick();
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    testsRun++;
    if (out_valid !== 4'b0000 || out !== '0 || rr_ptr !== 2'd0) begin
      testsFailed++;
      $display("[TB] FAIL reset_state: out_valid=%b out=%h rr_ptr=%0d, want 0000/0/0", out_valid, out, rr_ptr);
    end
    @(negedge clk);
    rst_n = 1'b1;
    modelReset();
    out_ready = '0; in_valid = 1'b0;
    for (int m = 0; m < 4; m++) begin
      mode = 2'(m);
      #1;
      testsRun++;
      if (in_ready !== (m != 3)) begin
        testsFailed++;
        $display("[TB] FAIL reset_ready_mode%0d: in_ready=%b, want %b", m, in_ready, (m != 3));
      end
    end
    mode = 2'b00;
    tick();
  endtask

  task automatic test_addressed_stall();
    doReset();
    mode = 2'b00; s = 2'd2; I = 8'hA5; in_valid = 1'b1; out_ready = '0;
    #1;
    testsRun++;
    if (in_ready !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL addr_ready_first: in_ready=%b, want 1", in_ready);
    end
    tick();
    testsRun++;
    if (out_valid !== 4'b0100 || out[2*WIDTH +: WIDTH] !== 8'hA5) begin
      testsFailed++;
      $display("[TB] FAIL addr_load: out_valid=%b ch2=%h, want 0100/a5", out_valid, out[2*WIDTH +: WIDTH]);
    end
    I = 8'h5A;
    #1;
    testsRun++;
    if (in_ready !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL addr_stall_ready: in_ready=%b, want 0", in_ready);
    end
    tick();
    testsRun++;
    if (out_valid !== 4'b0100 || out[2*WIDTH +: WIDTH] !== 8'hA5) begin
      testsFailed++;
      $display("[TB] FAIL addr_hold: out_valid=%b ch2=%h, want 0100/a5", out_valid, out[2*WIDTH +: WIDTH]);
    end
    out_ready = 4'b0100;
    #1;
    testsRun++;
    if (in_ready !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL addr_unstall_ready: in_ready=%b, want 1", in_ready);
    end
    tick();
    testsRun++;
    if (out_valid !== 4'b0100 || out[2*WIDTH +: WIDTH] !== 8'h5A) begin
      testsFailed++;
      $display("[TB] FAIL addr_second_beat: out_valid=%b ch2=%h, want 0100/5a", out_valid, out[2*WIDTH +: WIDTH]);
    end
    in_valid = 1'b0; out_ready = '1;
    tick();
    testsRun++;
    if (out_valid !== 4'b0000 || out[2*WIDTH +: WIDTH] !== 8'h5A) begin
      testsFailed++;
      $display("[TB] FAIL addr_drain_retain: out_valid=%b ch2=%h, want 0000/5a", out_valid, out[2*WIDTH +: WIDTH]);
    end
  endtask

  task automatic test_drain_load();
    doReset();
    mode = 2'b00; s = 2'd1; I = 8'h11; in_valid = 1'b1; out_ready = '0;
    tick();
    I = 8'h3C; out_ready = 4'b0010;
    #1;
    testsRun++;
    if (in_ready !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL drain_load_ready: in_ready=%b, want 1", in_ready);
    end
    tick();
    testsRun++;
    if (out_valid[1] !== 1'b1 || out[WIDTH +: WIDTH] !== 8'h3C) begin
      testsFailed++;
      $display("[TB] FAIL drain_load_data: valid1=%b ch1=%h, want 1/3c", out_valid[1], out[WIDTH +: WIDTH]);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_round_robin();
    doReset();
    mode = 2'b01; out_ready = '1; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      I = 8'(i + 1);
      #1;
      testsRun++;
      if (rr_ptr !== 2'(i % NCH) || in_ready !== 1'b1) begin
        testsFailed++;
        $display("[TB] FAIL rr_ptr_beat%0d: rr_ptr=%0d in_ready=%b, want %0d/1", i, rr_ptr, in_ready, i % NCH);
      end
      tick();
      testsRun++;
      if (out_valid !== (4'b0001 << (i % NCH)) || out[(i % NCH)*WIDTH +: WIDTH] !== 8'(i + 1)) begin
        testsFailed++;
        $display("[TB] FAIL rr_load_beat%0d: out_valid=%b ch=%h, want %b/%h", i, out_valid,
                 out[(i % NCH)*WIDTH +: WIDTH], 4'b0001 << (i % NCH), 8'(i + 1));
      end
    end
    in_valid = 1'b0;
    mode = 2'b00;
    #1;
    testsRun++;
    if (rr_ptr !== 2'd1) begin
      testsFailed++;
      $display("[TB] FAIL rr_final: rr_ptr=%0d, want 1", rr_ptr);
    end
  endtask

  task automatic test_broadcast();
    doReset();
    mode = 2'b00; s = 2'd3; I = 8'h77; in_valid = 1'b1; out_ready = '0;
    tick();
    mode = 2'b10; I = 8'hFF;
    #1;
    testsRun++;
    if (in_ready !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL bcast_blocked: in_ready=%b, want 0", in_ready);
    end
    tick();
    testsRun++;
    if (out_valid !== 4'b1000 || out[3*WIDTH +: WIDTH] !== 8'h77) begin
      testsFailed++;
      $display("[TB] FAIL bcast_no_load: out_valid=%b ch3=%h, want 1000/77", out_valid, out[3*WIDTH +: WIDTH]);
    end
    out_ready = 4'b1000;
    #1;
    testsRun++;
    if (in_ready !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL bcast_ready: in_ready=%b, want 1", in_ready);
    end
    tick();
    testsRun++;
    if (out_valid !== 4'b1111 || out !== 32'hFFFF_FFFF) begin
      testsFailed++;
      $display("[TB] FAIL bcast_load: out_valid=%b out=%h, want 1111/ffffffff", out_valid, out);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reserved();
    doReset();
    mode = 2'b01; I = 8'h42; in_valid = 1'b1; out_ready = '0;
    tick();
    mode = 2'b11; I = 8'h99;
    #1;
    testsRun++;
    if (in_ready !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL rsvd_ready: in_ready=%b, want 0", in_ready);
    end
    tick();
    testsRun++;
    if (out_valid !== 4'b0001 || rr_ptr !== 2'd1 || out !== 32'h0000_0042) begin
      testsFailed++;
      $display("[TB] FAIL rsvd_no_load: out_valid=%b rr_ptr=%0d out=%h, want 0001/1/00000042", out_valid, rr_ptr, out);
    end
    out_ready = 4'b0001;
    tick();
    testsRun++;
    if (out_valid !== 4'b0000 || rr_ptr !== 2'd1) begin
      testsFailed++;
      $display("[TB] FAIL rsvd_drain: out_valid=%b rr_ptr=%0d, want 0000/1", out_valid, rr_ptr);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    doReset();
    mode = 2'b01; in_valid = 1'b1; out_ready = '0;
    I = 8'hC0; tick();
    I = 8'hC1; tick();
    mode = 2'b00; s = 2'd3; I = 8'hC3; tick();
    in_valid = 1'b0;
    testsRun++;
    if (out_valid !== 4'b1011 || rr_ptr !== 2'd2) begin
      testsFailed++;
      $display("[TB] FAIL mid_setup: out_valid=%b rr_ptr=%0d, want 1011/2", out_valid, rr_ptr);
    end
    #2;
    rst_n = 1'b0;
    #1;
    testsRun++;
    if (out_valid !== 4'b0000 || out !== '0 || rr_ptr !== 2'd0) begin
      testsFailed++;
      $display("[TB] FAIL mid_async_reset: out_valid=%b out=%h rr_ptr=%0d, want 0000/0/0", out_valid, out, rr_ptr);
    end
    @(negedge clk);
    rst_n = 1'b1;
    modelReset();
    tick();
  endtask

  task automatic test_random();
    doReset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      mode      = 2'($urandom_range(0, 3));
      s         = 2'($urandom_range(0, NCH - 1));
      I         = 8'($urandom);
      in_valid  = ($urandom_range(0, 99) < 70);
      for (int k = 0; k < NCH; k++) out_ready[k] = ($urandom_range(0, 99) < 55);
      #1;
      testsRun++;
      if (in_ready !== modelReady()) begin
        testsFailed++;
        $display("[TB] FAIL rand_ready cyc%0d: in_ready=%b, want %b", cyc, in_ready, modelReady());
      end
      modelAdvance();
      tick();
      testsRun++;
      if (rr_ptr !== 2'(mRr)) begin
        testsFailed++;
        $display("[TB] FAIL rand_rr cyc%0d: rr_ptr=%0d, want %0d", cyc, rr_ptr, mRr);
      end
      for (int k = 0; k < NCH; k++) begin
        testsRun++;
        if (out_valid[k] !== mValid[k] || out[k*WIDTH +: WIDTH] !== mData[k]) begin
          testsFailed++;
          $display("[TB] FAIL rand_ch%0d cyc%0d: valid=%b data=%h, want %b/%h", k, cyc,
                   out_valid[k], out[k*WIDTH +: WIDTH], mValid[k], mData[k]);
        end
      end
    end
    in_valid = 1'b0;
  endtask

  initial begin
    testsRun = 0;
    testsFailed = 0;
    rst_n = 1'b1; I = '0; in_valid = 1'b0; s = '0; mode = 2'b00; out_ready = '0;
    modelReset();
    #3;
    test_reset();
    test_addressed_stall();
    test_drain_load();
    test_round_robin();
    test_broadcast();
    test_reserved();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
